// File: rtl/regfile_access_ctrl_if.sv
// Pipeline-facing read/write request bus and regfile-facing port of the
// register file access controller. The controller binds to the slave modport.
interface regfile_access_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   // Handshakes: a transfer happens on a posedge where valid && ready are both
   // high. Valid must not depend combinationally on ready. rspValid carries no
   // ready; the consumer must take the response in the cycle it is shown.
   logic              reqValid;
   logic              reqReady;
   logic [ADDR_W-1:0] reqReg1;
   logic [ADDR_W-1:0] reqReg2;
   logic              rspValid;
   logic [DATA_W-1:0] rspData1;
   logic [DATA_W-1:0] rspData2;
   logic              wrValid;
   logic              wrReady;
   logic [ADDR_W-1:0] wrReg;
   logic [DATA_W-1:0] wrData;
   logic              rfWrite;
   logic [ADDR_W-1:0] rfWriteReg;
   logic [DATA_W-1:0] rfWriteData;
   logic [ADDR_W-1:0] rfReadReg1;
   logic [ADDR_W-1:0] rfReadReg2;
   logic [DATA_W-1:0] rfReadData1;
   logic [DATA_W-1:0] rfReadData2;

   modport master (
      output reqValid, reqReg1, reqReg2, wrValid, wrReg, wrData,
      output rfReadData1, rfReadData2,
      input  reqReady, rspValid, rspData1, rspData2, wrReady,
      input  rfWrite, rfWriteReg, rfWriteData, rfReadReg1, rfReadReg2
   );

   modport slave (
      input  reqValid, reqReg1, reqReg2, wrValid, wrReg, wrData,
      input  rfReadData1, rfReadData2,
      output reqReady, rspValid, rspData1, rspData2, wrReady,
      output rfWrite, rfWriteReg, rfWriteData, rfReadReg1, rfReadReg2
   );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register file access controller: queues writes and drains one per cycle,
// and answers reads one cycle later with queued data bypassed over the regfile.
module regfile_access_ctrl #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int WQ_DEPTH = 4
) (
   input logic                 clk,
   input logic                 reset,
   regfile_access_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(WQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] q_reg  [WQ_DEPTH];
   logic [DATA_W-1:0] q_data [WQ_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic q_full;
   logic q_empty;
   logic enq;
   logic deq;

   assign q_full  = (count == CNT_W'(WQ_DEPTH));
   assign q_empty = (count == '0);
   // Writes to register 0 are handshaken but never stored.
   assign enq     = bus.wrValid && !q_full && (bus.wrReg != '0);
   assign deq     = !q_empty;

   assign bus.wrReady     = !q_full;
   assign bus.reqReady    = 1'b1;
   assign bus.rfWrite     = deq;
   assign bus.rfWriteReg  = q_reg[rd_ptr];
   assign bus.rfWriteData = q_data[rd_ptr];
   assign bus.rfReadReg1  = bus.reqReg1;
   assign bus.rfReadReg2  = bus.reqReg2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         q_reg[wr_ptr]  <= bus.wrReg;
         q_data[wr_ptr] <= bus.wrData;
      end
   end

   // Youngest-match search: walk from head to tail so later hits overwrite earlier ones.
   logic              hit1, hit2;
   logic [DATA_W-1:0] byp1, byp2;
   logic [PTR_W-1:0]  idx;

   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      byp1 = '0;
      byp2 = '0;
      idx  = '0;
      for (int k = 0; k < WQ_DEPTH; k++) begin
         idx = rd_ptr + PTR_W'(k);
         if (CNT_W'(k) < count) begin
            if (q_reg[idx] == bus.reqReg1) begin
               hit1 = 1'b1;
               byp1 = q_data[idx];
            end
            if (q_reg[idx] == bus.reqReg2) begin
               hit2 = 1'b1;
               byp2 = q_data[idx];
            end
         end
      end
   end

   logic              zero1, zero2;
   logic              rsp_pend;
   logic              use_q1, use_q2;
   logic [DATA_W-1:0] q_val1, q_val2;
   logic [DATA_W-1:0] last1, last2;
   logic [DATA_W-1:0] resp1, resp2;

   assign zero1 = (bus.reqReg1 == '0);
   assign zero2 = (bus.reqReg2 == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_pend <= 1'b0;
         use_q1   <= 1'b0;
         use_q2   <= 1'b0;
         q_val1   <= '0;
         q_val2   <= '0;
         last1    <= '0;
         last2    <= '0;
      end else begin
         rsp_pend <= bus.reqValid;
         if (bus.reqValid) begin
            use_q1 <= zero1 || hit1;
            use_q2 <= zero2 || hit2;
            q_val1 <= zero1 ? '0 : byp1;
            q_val2 <= zero2 ? '0 : byp2;
         end
         if (rsp_pend) begin
            last1 <= resp1;
            last2 <= resp2;
         end
      end
   end

   // The regfile's registered read lands in the response cycle, so its data is muxed in here.
   assign resp1 = use_q1 ? q_val1 : bus.rfReadData1;
   assign resp2 = use_q2 ? q_val2 : bus.rfReadData2;

   assign bus.rspValid = rsp_pend;
   assign bus.rspData1 = rsp_pend ? resp1 : last1;
   assign bus.rspData2 = rsp_pend ? resp2 : last2;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural regfile plus an architectural
// register model; every read must see all writes accepted before it.
module tb_regfile_access_ctrl;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 4;

   typedef struct {
      logic [AW-1:0] r;
      logic [DW-1:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WQ_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Regfile: registered read returning the pre-write value on a same-edge write.
   logic [DW-1:0] rf_mem [32];
   logic          pre_en;
   logic [AW-1:0] pre_addr;
   logic [DW-1:0] pre_data;

   always @(posedge clk) begin
      bus.rfReadData1 <= rf_mem[bus.rfReadReg1];
      bus.rfReadData2 <= rf_mem[bus.rfReadReg2];
      if (pre_en) rf_mem[pre_addr] <= pre_data;
      else if (bus.rfWrite) rf_mem[bus.rfWriteReg] <= bus.rfWriteData;
   end

   // Reference model state
   logic [DW-1:0]   arch [32];
   wr_t             wq[$];
   logic [2*DW-1:0] exp_q[$];
   logic [DW-1:0]   last1, last2;
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] arch_rd(input logic [AW-1:0] r);
      return (r == '0) ? '0 : arch[r];
   endfunction

   task automatic set_wr(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
      bus.wrValid = v;
      bus.wrReg   = r;
      bus.wrData  = d;
   endtask

   task automatic set_rd(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      bus.reqValid = v;
      bus.reqReg1  = r1;
      bus.reqReg2  = r2;
   endtask

   task automatic idle();
      set_wr(1'b0, '0, '0);
      set_rd(1'b0, '0, '0);
   endtask

   // One clock cycle: check outputs against the model, advance the model, clock.
   task automatic tick();
      logic            w_acc;
      logic [2*DW-1:0] e;
      #1;
      check("rfWrite", 32'(bus.rfWrite), 32'(wq.size() != 0));
      if (wq.size() != 0) begin
         check("rfWriteReg", 32'(bus.rfWriteReg), 32'(wq[0].r));
         check("rfWriteData", bus.rfWriteData, wq[0].d);
      end
      check("wrReady", 32'(bus.wrReady), 32'(wq.size() < DEPTH));
      check("reqReady", 32'(bus.reqReady), 32'd1);
      check("rspValid", 32'(bus.rspValid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         e     = exp_q.pop_front();
         last1 = e[2*DW-1:DW];
         last2 = e[DW-1:0];
      end
      check("rspData1", bus.rspData1, last1);
      check("rspData2", bus.rspData2, last2);

      w_acc = bus.wrValid && (wq.size() < DEPTH);
      if (bus.reqValid) exp_q.push_back({arch_rd(bus.reqReg1), arch_rd(bus.reqReg2)});
      if (wq.size() != 0) void'(wq.pop_front());
      if (w_acc && bus.wrReg != '0) begin
         wq.push_back('{r: bus.wrReg, d: bus.wrData});
         arch[bus.wrReg] = bus.wrData;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_checks(input string tag);
      #1;
      check({tag, "_rfWrite"}, 32'(bus.rfWrite), 32'd0);
      check({tag, "_rspValid"}, 32'(bus.rspValid), 32'd0);
      check({tag, "_wrReady"}, 32'(bus.wrReady), 32'd1);
      check({tag, "_reqReady"}, 32'(bus.reqReady), 32'd1);
      check({tag, "_rspData1"}, bus.rspData1, '0);
      check({tag, "_rspData2"}, bus.rspData2, '0);
   endtask

   initial begin
      reset  = 1'b1;
      pre_en = 1'b0;
      pre_addr = '0;
      pre_data = '0;
      last1  = '0;
      last2  = '0;
      idle();
      @(negedge clk);
      // Preload the regfile while the controller is held in reset.
      for (int r = 0; r < 32; r++) begin
         pre_en   = 1'b1;
         pre_addr = AW'(r);
         pre_data = (r == 0 || r == 7) ? '0 : $urandom;
         arch[r]  = pre_data;
         @(negedge clk);
      end
      pre_en = 1'b0;
      reset_checks("reset_init");
      reset = 1'b0;
      tick();

      // r5 via the regfile path after the queue has drained
      set_wr(1'b1, 5'd5, 32'hA5A5_A5A5); tick();
      idle(); tick(); tick();
      set_rd(1'b1, 5'd5, 5'd0); tick();
      idle(); tick();
      check("r5_value", last1, 32'hA5A5_A5A5);

      // youngest bypass, second port from the regfile
      set_wr(1'b1, 5'd3, 32'h11); tick();
      set_wr(1'b1, 5'd3, 32'h22); tick();
      idle(); set_rd(1'b1, 5'd3, 5'd4); tick();
      idle(); tick();
      check("r3_youngest", last1, 32'h22);

      // same-cycle write is not visible to the read
      set_wr(1'b1, 5'd7, 32'h99); set_rd(1'b1, 5'd7, 5'd7); tick();
      idle(); set_rd(1'b1, 5'd7, 5'd0); tick();
      check("r7_same_cycle", last1, 32'h0);
      idle(); tick();
      check("r7_next_cycle", last1, 32'h99);

      // back-to-back burst of five writes, then read all back
      for (int i = 0; i < 5; i++) begin
         set_wr(1'b1, AW'(10 + i), $urandom); tick();
      end
      idle();
      set_rd(1'b1, 5'd10, 5'd11); tick();
      set_rd(1'b1, 5'd12, 5'd13); tick();
      set_rd(1'b1, 5'd14, 5'd0);  tick();
      idle(); tick(); tick();

      // writes to r0 are dropped
      set_wr(1'b1, 5'd0, 32'hFFFF_FFFF); tick();
      idle(); set_rd(1'b1, 5'd0, 5'd0); tick();
      idle(); tick();
      check("r0_read", last1, 32'h0);

      // reset in the middle of a write burst with a read in flight
      set_wr(1'b1, 5'd20, $urandom); tick();
      set_wr(1'b1, 5'd21, $urandom); set_rd(1'b1, 5'd20, 5'd21); tick();
      idle();
      reset = 1'b1;
      reset_checks("reset_mid");
      wq.delete();
      exp_q.delete();
      last1 = '0;
      last2 = '0;
      for (int r = 0; r < 32; r++) arch[r] = rf_mem[r];
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick();
      set_rd(1'b1, 5'd20, 5'd21); tick();
      idle(); tick();
      check("post_reset_r20", last1, arch_rd(5'd20));

      // randomized traffic, narrow register range to exercise bypass
      for (int i = 0; i < 400; i++) begin
         set_wr(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
         set_rd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
         tick();
      end
      idle();
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
